// File: rtl/router_pkg.sv
// Shared router definitions: flit geometry, channel direction indices and
// the side-buffer controller state type.
package router_pkg;

  localparam int FLIT_W = 11;

  localparam int DIR_N = 0;
  localparam int DIR_S = 1;
  localparam int DIR_E = 2;
  localparam int DIR_W = 3;

  // Flit field layout: destination address in the low bits, payload above.
  localparam int DST_LSB = 0;
  localparam int DST_W   = 4;
  localparam int PAY_LSB = DST_LSB + DST_W;
  localparam int PAY_W   = FLIT_W - PAY_LSB;

  typedef enum logic {
    IDLE,
    HOLD
  } sb_state_t;

endpackage

// File: rtl/side_buffer_reinject_fifo.sv
// Synchronous FIFO for the side buffer; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module sync_fifo #(
  parameter int FLIT_W = 11,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [FLIT_W-1:0]          din,
  output logic [FLIT_W-1:0]          head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/side_buffer_reinject.sv
// Side-buffer receive stage: registers the four router channels and
// re-injects buffered flits into the first free slot, flagging starvation.
module side_buffer_reinject
  import router_pkg::*;
#(
  parameter int FLIT_W       = router_pkg::FLIT_W,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [FLIT_W-1:0]       buf_in,
  input  logic                    buf_in_valid,
  input  logic [FLIT_W-1:0]       n_in,
  input  logic [FLIT_W-1:0]       s_in,
  input  logic [FLIT_W-1:0]       e_in,
  input  logic [FLIT_W-1:0]       w_in,
  input  logic [3:0]              ch_valid_in,
  output logic [FLIT_W-1:0]       n_out,
  output logic [FLIT_W-1:0]       s_out,
  output logic [FLIT_W-1:0]       e_out,
  output logic [FLIT_W-1:0]       w_out,
  output logic [3:0]              ch_valid_out,
  output logic                    buf_full,
  output logic [$clog2(DEPTH):0]  buf_count,
  output logic                    force_redirect
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  logic [FLIT_W-1:0] head;
  logic              empty;
  logic              pop_ok;
  logic              push_ok;
  logic [3:0]        inject;
  logic [SW-1:0]     starve_cnt;
  logic              overflow;
  sb_state_t         state;

  // The head only comes from already-stored entries, so there is no bypass.
  assign pop_ok  = !empty && (ch_valid_in != 4'hF);
  assign push_ok = buf_in_valid && (!buf_full || pop_ok);

  sync_fifo #(
    .FLIT_W (FLIT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (buf_in_valid),
    .pop   (pop_ok),
    .din   (buf_in),
    .head  (head),
    .count (buf_count),
    .full  (buf_full),
    .empty (empty)
  );

  always_comb begin
    inject = '0;
    if (pop_ok) begin
      if (!ch_valid_in[DIR_N])      inject[DIR_N] = 1'b1;
      else if (!ch_valid_in[DIR_S]) inject[DIR_S] = 1'b1;
      else if (!ch_valid_in[DIR_E]) inject[DIR_E] = 1'b1;
      else                          inject[DIR_W] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_out        <= '0;
      s_out        <= '0;
      e_out        <= '0;
      w_out        <= '0;
      ch_valid_out <= '0;
      overflow     <= 1'b0;
    end else begin
      n_out        <= inject[DIR_N] ? head : n_in;
      s_out        <= inject[DIR_S] ? head : s_in;
      e_out        <= inject[DIR_E] ? head : e_in;
      w_out        <= inject[DIR_W] ? head : w_in;
      ch_valid_out <= ch_valid_in | inject;
      if (buf_in_valid && !push_ok) overflow <= 1'b1;
    end
  end

  // Counter saturates at the limit; force_redirect is raised one cycle later
  // and held until the head finally leaves.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      starve_cnt     <= '0;
      force_redirect <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (push_ok) state <= HOLD;
        HOLD:    if (pop_ok && !push_ok && buf_count == CW'(1)) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (pop_ok || empty) begin
        starve_cnt     <= '0;
        force_redirect <= 1'b0;
      end else begin
        if (starve_cnt != LIMIT_C) starve_cnt <= starve_cnt + 1'b1;
        if (state == HOLD && starve_cnt == LIMIT_C) force_redirect <= 1'b1;
      end
    end
  end

  a_overflow_sticky: assert property (@(posedge clk) disable iff (rst) overflow |=> overflow);
  a_force_in_hold:   assert property (@(posedge clk) disable iff (rst) force_redirect |-> state == HOLD);

endmodule
